// File: rtl/adder_sub_self_test.sv
// Exhaustive self-test controller for a 1-bit full adder/subtractor: walks all 16
// {mode,a,b,cin} vectors, waits SETTLE_CYCLES per vector, and tallies mismatches.
module adder_sub_self_test #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       dut_a,
   output logic       dut_b,
   output logic       dut_cin,
   output logic       dut_mode,
   input  logic       dut_result,
   input  logic       dut_cout_brw,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [3:0] first_fail_vec,
   output logic       first_fail_valid
);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] vec;
   logic [3:0] settle_cnt;

   logic       golden_result;
   logic       golden_cout_brw;
   logic       mismatch;
   logic [4:0] err_next;

   // Stimulus comes straight from the vector register, so the DUT sees no glitches.
   assign {dut_mode, dut_a, dut_b, dut_cin} = vec;

   assign golden_result   = dut_a ^ dut_b ^ dut_cin;
   assign golden_cout_brw = dut_mode ? ((~dut_a & dut_b) | (~dut_a & dut_cin) | (dut_b & dut_cin))
                                     : (( dut_a & dut_b) | ( dut_a & dut_cin) | (dut_b & dut_cin));
   assign mismatch        = (dut_result != golden_result) || (dut_cout_brw != golden_cout_brw);
   assign err_next        = err_count + 5'(mismatch);

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         vec              <= '0;
         settle_cnt       <= '0;
         err_count        <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state            <= SETTLE;
                  vec              <= '0;
                  settle_cnt       <= RELOAD;
                  err_count        <= '0;
                  first_fail_vec   <= '0;
                  first_fail_valid <= 1'b0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  pass             <= 1'b0;
               end
            end
            SETTLE: begin
               if (settle_cnt == 4'd0) state <= CHECK;
               else                    settle_cnt <= settle_cnt - 4'd1;
            end
            CHECK: begin
               err_count <= err_next;
               if (mismatch && !first_fail_valid) begin
                  first_fail_vec   <= vec;
                  first_fail_valid <= 1'b1;
               end
               if (vec == 4'd15) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  // NOTE: pass uses err_next so it agrees with err_count on the first DONE cycle.
                  pass  <= (err_next == 5'd0);
               end else begin
                  state      <= SETTLE;
                  vec        <= vec + 4'd1;
                  settle_cnt <= RELOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_sub_self_test.sv
// Scoreboard bench: two controllers (SETTLE_CYCLES 1 and 3) drive a behavioural
// adder/subtractor with selectable faults; run summaries are checked on done.
module tb_adder_sub_self_test;

   typedef struct {
      logic [4:0] err_count;
      logic [3:0] ffv;
      logic       ffv_valid;
      logic       pass;
      int         done_cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int fault  = 0;  // 0 good, 1 result stuck 0, 2 ignores mode, 3 cout inverted

   exp_t q1[$];
   exp_t q3[$];

   // Controller with SETTLE_CYCLES = 1
   logic       rst1, start1, a1, b1, cin1, mode1, res1, co1;
   logic       busy1, done1, pass1, ffvalid1;
   logic [4:0] err1;
   logic [3:0] ffv1;

   // Controller with SETTLE_CYCLES = 3
   logic       rst3, start3, a3, b3, cin3, mode3, res3, co3;
   logic       busy3, done3, pass3, ffvalid3;
   logic [4:0] err3;
   logic [3:0] ffv3;

   adder_sub_self_test #(.SETTLE_CYCLES(1)) u1 (
      .clk(clk), .rst(rst1), .start(start1),
      .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_mode(mode1),
      .dut_result(res1), .dut_cout_brw(co1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
   );

   adder_sub_self_test #(.SETTLE_CYCLES(3)) u3 (
      .clk(clk), .rst(rst3), .start(start3),
      .dut_a(a3), .dut_b(b3), .dut_cin(cin3), .dut_mode(mode3),
      .dut_result(res3), .dut_cout_brw(co3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .first_fail_vec(ffv3), .first_fail_valid(ffvalid3)
   );

   function automatic logic [1:0] model(input int f, input logic m, input logic a,
                                        input logic b, input logic c);
      logic r, carry, borrow, co;
      r      = a ^ b ^ c;
      carry  = (a & b) | (a & c) | (b & c);
      borrow = (~a & b) | (~a & c) | (b & c);
      co     = m ? borrow : carry;
      if (f == 1) r  = 1'b0;
      if (f == 2) co = carry;
      if (f == 3) co = ~co;
      return {r, co};
   endfunction

   assign {res1, co1} = model(fault, mode1, a1, b1, cin1);
   assign {res3, co3} = model(fault, mode3, a3, b3, cin3);

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic score(input string tag, input exp_t e, input logic [4:0] ec,
                        input logic [3:0] fv, input logic fvv, input logic p);
      check({tag, ".err_count"},        int'(ec),  int'(e.err_count));
      check({tag, ".first_fail_vec"},   int'(fv),  int'(e.ffv));
      check({tag, ".first_fail_valid"}, int'(fvv), int'(e.ffv_valid));
      check({tag, ".pass"},             int'(p),   int'(e.pass));
      check({tag, ".done_cycle"},       cyc,       e.done_cyc);
   endtask

   // Monitors: pop an expectation each time done rises.
   logic prev1 = 1'b0, prev3 = 1'b0;
   always @(negedge clk) begin
      if (done1 && !prev1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1.unexpected_done: got done with empty scoreboard");
         end else score("u1", q1.pop_front(), err1, ffv1, ffvalid1, pass1);
      end
      prev1 = done1;
   end

   always @(negedge clk) begin
      if (done3 && !prev3) begin
         if (q3.size() == 0) begin
            checks++; errors++;
            $display("FAIL u3.unexpected_done: got done with empty scoreboard");
         end else score("u3", q3.pop_front(), err3, ffv3, ffvalid3, pass3);
      end
      prev3 = done3;
   end

   // Pulse start on u1 and queue the expected summary once the start edge has passed.
   task automatic run1(input logic [4:0] ec, input logic [3:0] fv, input logic fvv,
                       input logic p);
      exp_t e;
      @(negedge clk) start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      e = '{ec, fv, fvv, p, cyc + 32};
      q1.push_back(e);
   endtask

   task automatic wait_done1(input string name);
      int n = 0;
      while (!done1 && n < 200) begin @(negedge clk); n++; end
      if (!done1) begin
         checks++; errors++;
         $display("FAIL %s: timeout got done=0 expected done=1", name);
      end
      @(negedge clk);
   endtask

   task automatic wait_done3(input string name);
      int n = 0;
      while (!done3 && n < 300) begin @(negedge clk); n++; end
      if (!done3) begin
         checks++; errors++;
         $display("FAIL %s: timeout got done=0 expected done=1", name);
      end
      @(negedge clk);
   endtask

   task automatic check_idle1(input string tag);
      check({tag, ".busy"},      int'(busy1), 0);
      check({tag, ".done"},      int'(done1), 0);
      check({tag, ".pass"},      int'(pass1), 0);
      check({tag, ".err_count"}, int'(err1),  0);
      check({tag, ".ffv"},       int'(ffv1),  0);
      check({tag, ".ffvalid"},   int'(ffvalid1), 0);
      check({tag, ".dut_vec"},   int'({mode1, a1, b1, cin1}), 0);
   endtask

   initial begin
      exp_t e;
      logic [4:0] held_err;
      rst1 = 1'b1; start1 = 1'b0;
      rst3 = 1'b1; start3 = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_idle1("reset");
      @(negedge clk) rst1 = 1'b0; rst3 = 1'b0;

      // Good DUT: clean pass, 32-cycle run.
      fault = 0;
      run1(5'd0, 4'b0000, 1'b0, 1'b1);
      @(negedge clk) check("busy_in_run", int'(busy1), 1);
      wait_done1("good_run");
      held_err = err1;
      repeat (5) @(negedge clk);
      check("done_persists", int'(done1), 1);
      check("err_stable",    int'(err1),  int'(held_err));
      check("pass_persists", int'(pass1), 1);
      check("dut_vec_done",  int'({mode1, a1, b1, cin1}), 15);

      // Faulty DUTs, each restarted directly from DONE.
      fault = 1; run1(5'd8,  4'b0001, 1'b1, 1'b0); wait_done1("stuck_result");
      fault = 2; run1(5'd4,  4'b1001, 1'b1, 1'b0); wait_done1("ignore_mode");
      fault = 3; run1(5'd16, 4'b0000, 1'b1, 1'b0); wait_done1("cout_inverted");

      // Mid-run reset, with start held high to confirm reset priority.
      fault = 2;
      @(negedge clk) start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      repeat (9) @(posedge clk);
      #1 check("busy_before_rst", int'(busy1), 1);
      @(negedge clk) rst1 = 1'b1; start1 = 1'b1;
      @(posedge clk); #1 check_idle1("midrun_rst");
      @(negedge clk) rst1 = 1'b0; start1 = 1'b0;
      fault = 0;
      run1(5'd0, 4'b0000, 1'b0, 1'b1);
      wait_done1("after_rst_run");

      // SETTLE_CYCLES=3: start while busy is ignored; restart from DONE clears counts.
      @(negedge clk) start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      e = '{5'd0, 4'b0000, 1'b0, 1'b1, cyc + 64};
      q3.push_back(e);
      repeat (6) @(posedge clk);
      #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      wait_done3("s3_first");
      fault = 1;
      @(negedge clk) start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      check("s3_restart_clear", int'(err3), 0);
      e = '{5'd8, 4'b0001, 1'b1, 1'b0, cyc + 64};
      q3.push_back(e);
      wait_done3("s3_second");

      check("q1_drained", q1.size(), 0);
      check("q3_drained", q3.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_sub_self_test.md
ADDER_SUB_SELF_TEST -- requirements
Module: adder_sub_self_test

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles each vector is held on the DUT before sampling (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin exhaustive test run; sampled only in IDLE or DONE.
REQ-005 SHALL have port dut_a, dut_b, dut_cin  output  1 each  operand and carry/borrow-in bits driven to the DUT.
REQ-006 SHALL have port dut_mode  output  1  0 = add, 1 = subtract, driven to the DUT.
REQ-007 SHALL have port dut_result  input  1  DUT sum or difference bit.
REQ-008 SHALL have port dut_cout_brw  input  1  DUT carry-out (add) or borrow-out (subtract).
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  high while in DONE, i.e. results valid.
REQ-011 SHALL have port pass  output  1  high in DONE when err_count is 0; low otherwise.
REQ-012 SHALL have port err_count  output  5  number of mismatching vectors in current/last run (0..16).
REQ-013 SHALL have port first_fail_vec  output  4  {mode,a,b,cin} of first mismatching vector.
REQ-014 SHALL have port first_fail_valid  output  1  high once any mismatch has been recorded in the run.

Function
REQ-015 SHALL implement states IDLE, SETTLE, CHECK, DONE.
REQ-016 SHALL hold a 4-bit vector index vec = {mode,a,b,cin}; dut_mode/dut_a/dut_b/dut_cin SHALL equal vec bits directly from the register (no combinational path from inputs).
REQ-017 SHALL drive DUT outputs to 0 in IDLE.
REQ-018 IDLE or DONE with start=1: vec<=0, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, settle counter<=SETTLE_CYCLES-1, next state SETTLE.
REQ-019 SETTLE: counter decrements each cycle; at counter 0 next state CHECK.
REQ-020 CHECK (exactly one cycle): compare dut_result/dut_cout_brw against golden for vec; mismatch in either bit increments err_count by 1 (once per vector).
REQ-021 Golden result SHALL be a^b^cin for both modes.
REQ-022 Golden mode 0 cout SHALL be (a&b)|(a&cin)|(b&cin); golden mode 1 borrow SHALL be (~a&b)|(~a&cin)|(b&cin).
REQ-023 On first mismatch of a run, first_fail_vec<=vec and first_fail_valid<=1; later mismatches SHALL NOT change them.
REQ-024 CHECK with vec<15: vec<=vec+1, counter reloaded, next SETTLE; with vec==15: next DONE, vec not incremented (no wrap).
REQ-025 Total run length SHALL be 16*(SETTLE_CYCLES+1) cycles from the start-accepting edge to DONE entry.
REQ-026 busy SHALL be high in SETTLE and CHECK only; done high in DONE only; pass = done & (err_count==0).
REQ-027 start while busy SHALL be ignored; DONE SHALL persist with results stable until start or rst.
REQ-028 err_count SHALL not overflow (max 16 fits 5 bits).

Reset
REQ-029 rst=1 SHALL, in any state including mid-run, force IDLE, vec=0, counter=0, err_count=0, first_fail_vec=0, first_fail_valid=0, busy=0, done=0, pass=0, DUT outputs 0; rst SHALL take priority over start.

Verification
REQ-030 Correct behavioural DUT, SETTLE_CYCLES=1, start pulse -> done rises 32 cycles later, pass=1, err_count=0, first_fail_valid=0.
REQ-031 DUT result stuck at 0 -> err_count=8, first_fail_vec=4'b0001, first_fail_valid=1, pass=0.
REQ-032 DUT ignoring mode (always adds) -> err_count=4, first_fail_vec=4'b1001, pass=0.
REQ-033 DUT cout_brw inverted -> err_count=16, first_fail_vec=4'b0000.
REQ-034 rst asserted 10 cycles into a run -> next cycle IDLE, all outputs 0; new start gives a full clean 32-cycle run.
REQ-035 start pulsed while busy, then again in DONE with SETTLE_CYCLES=3 -> first ignored, second restarts with counts cleared, done after 64 cycles.
